// File: rtl/tdc_pkg.sv
// tdc_pkg: shared constants for the time-result buffering path.
//   TIMEDATA_W    - width of one measurement result (ps)
//   RD_W          - width of one word handed to the SDK/SD-card path
//   DEFAULT_DEPTH - default number of 64-bit FIFO entries
//   OUT_*         - one-hot states of the output serialiser
package tdc_pkg;

  localparam int TIMEDATA_W    = 64;
  localparam int RD_W          = 32;
  localparam int DEFAULT_DEPTH = 16;

  localparam logic [2:0] OUT_IDLE = 3'b001;
  localparam logic [2:0] OUT_LO   = 3'b010;
  localparam logic [2:0] OUT_HI   = 3'b100;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: single-clock FIFO storage with a registered read port.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clear          synchronous flush of pointers and count (has priority)
//   push, wdata    write wdata at the tail (ignored when full)
//   pop, rdata     load the head into rdata on the edge (ignored when empty);
//                  rdata then holds that value until the next pop
//   count          number of stored entries (0..DEPTH)
//   full, empty    count == DEPTH / count == 0
module sync_fifo_mem
  import tdc_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = TIMEDATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic push_ok;
  logic pop_ok;

  // Internal guards so a misbehaving caller can never corrupt the pointers.
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;

  // Storage array kept free of reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      rdata_reg  <= '0;
    end else if (clear) begin
      // rdata_reg is left alone: the consumer side keeps its last word.
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        rdata_reg  <= mem[rd_ptr_reg];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata = rdata_reg;
  assign count = count_reg;
  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

endmodule

// File: rtl/time_result_fifo.sv
// time_result_fifo: buffers 64-bit measurement results and serialises each
// one as two 32-bit words (low half first) over a valid/ready handshake.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   done, timedata    one-cycle strobe with the result to store
//   clear             synchronous flush of FIFO, output stage and drop state
//   rd_ready          consumer accepts rd_data this cycle
//   rd_valid, rd_data, rd_last   output word; rd_last marks the high half
//   count, full, empty           FIFO occupancy (output stage excluded)
//   overflow, drop_cnt           sticky drop flag, saturating drop counter
module time_result_fifo
  import tdc_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  done,
  input  logic [TIMEDATA_W-1:0] timedata,
  input  logic                  clear,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [RD_W-1:0]       rd_data,
  output logic                  rd_last,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [15:0]           drop_cnt
);

  logic [2:0]            state_reg;
  logic [2:0]            state_next;
  logic                  sel_hi_reg;
  logic                  sel_hi_next;
  logic                  overflow_reg;
  logic [15:0]           drop_cnt_reg;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [TIMEDATA_W-1:0] fifo_rdata;
  logic                  drop;

  // full is the pre-edge value, so a push into a full FIFO is lost even if
  // the output stage pops on the same edge.
  assign fifo_push = done && !fifo_full && !clear;
  assign drop      = done && fifo_full && !clear;

  // The FIFO's registered read port doubles as the 64-bit output register.
  sync_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (TIMEDATA_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (timedata),
    .rdata   (fifo_rdata),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      OUT_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = OUT_LO;
        end
      end
      OUT_LO: begin
        if (rd_ready) begin
          state_next = OUT_HI;
        end
      end
      OUT_HI: begin
        if (rd_ready) begin
          if (!fifo_empty) begin
            // Back-to-back: next result's low word follows with no bubble.
            fifo_pop   = 1'b1;
            state_next = OUT_LO;
          end else begin
            state_next = OUT_IDLE;
          end
        end
      end
      default: state_next = OUT_IDLE;
    endcase
    if (clear) begin
      state_next = OUT_IDLE;
      fifo_pop   = 1'b0;
    end
  end

  // Half select: cleared on a fresh pop, set when moving to the high word,
  // otherwise held so rd_data keeps its last value while idle.
  always_comb begin
    sel_hi_next = sel_hi_reg;
    if (state_next == OUT_HI) begin
      sel_hi_next = 1'b1;
    end else if (fifo_pop) begin
      sel_hi_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= OUT_IDLE;
      sel_hi_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sel_hi_reg <= sel_hi_next;
      if (clear) begin
        overflow_reg <= 1'b0;
        drop_cnt_reg <= '0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 16'hFFFF) begin
          drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign rd_valid = (state_reg != OUT_IDLE);
  assign rd_last  = (state_reg == OUT_HI);
  assign rd_data  = sel_hi_reg ? fifo_rdata[TIMEDATA_W-1:RD_W] : fifo_rdata[RD_W-1:0];
  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_time_result_fifo.sv
// tb_time_result_fifo: directed scenarios with literal expectations plus a
// randomized phase; a queue-based model of the buffer is compared against
// the DUT outputs on every falling clock edge.
module tb_time_result_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic        clk;
  logic        reset_n;
  logic        done;
  logic [63:0] timedata;
  logic        clear;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic [ADDR_W:0] count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  time_result_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .done     (done),
    .timedata (timedata),
    .clear    (clear),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Results waiting in the buffer, plus one result being presented and
  // which half of it is on the bus.
  logic [63:0] mq[$];
  bit          m_valid;
  bit          m_hi;
  logic [63:0] m_data;
  logic [31:0] m_word;
  bit          m_ovf;
  int          m_drops;

  always @(posedge clk or negedge reset_n) begin
    int  pre_size;
    bit  was_full;
    if (!reset_n) begin
      mq.delete();
      m_valid = 0; m_hi = 0; m_data = '0; m_word = '0; m_ovf = 0; m_drops = 0;
    end else if (clear) begin
      mq.delete();
      m_valid = 0; m_hi = 0; m_ovf = 0; m_drops = 0;
    end else begin
      pre_size = mq.size();
      was_full = (pre_size == DEPTH);
      if (!m_valid) begin
        if (pre_size > 0) begin
          m_data = mq.pop_front(); m_valid = 1; m_hi = 0;
        end
      end else if (rd_ready) begin
        if (!m_hi) m_hi = 1;
        else if (pre_size > 0) begin
          m_data = mq.pop_front(); m_hi = 0;
        end else m_valid = 0;
      end
      if (done) begin
        if (was_full) begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end else mq.push_back(timedata);
      end
      if (m_valid) m_word = m_hi ? m_data[63:32] : m_data[31:0];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("rd_valid", rd_valid, m_valid);
    check("rd_last",  rd_last,  m_valid && m_hi);
    check("rd_data",  rd_data,  m_word);
    check("count",    count,    mq.size());
    check("full",     full,     mq.size() == DEPTH);
    check("empty",    empty,    mq.size() == 0);
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drops);
  end

  // ---------------- helpers ----------------
  task automatic push_one(input logic [63:0] v);
    done = 1'b1; timedata = v;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic wait_valid(input int n);
    int k = 0;
    while (!rd_valid && k < n) begin
      @(negedge clk);
      k++;
    end
    check("wait_valid_timeout", rd_valid, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got[$];
    logic [31:0] lo;
    reset_n = 1'b0; done = 1'b0; timedata = '0; clear = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data",  rd_data,  32'h0);
    check("rst_rd_last",  rd_last,  1'b0);
    check("rst_count",    count,    5'd0);
    check("rst_empty",    empty,    1'b1);
    check("rst_full",     full,     1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop_cnt", drop_cnt, 16'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single result, latency N+2
    rd_ready = 1'b1;
    push_one(64'h0000_0001_0000_9C40);
    check("single_n1_valid", rd_valid, 1'b0);
    check("single_n1_count", count, 5'd1);
    @(negedge clk);
    check("single_lo_valid", rd_valid, 1'b1);
    check("single_lo_data",  rd_data,  32'h0000_9C40);
    check("single_lo_last",  rd_last,  1'b0);
    @(negedge clk);
    check("single_hi_valid", rd_valid, 1'b1);
    check("single_hi_data",  rd_data,  32'h0000_0001);
    check("single_hi_last",  rd_last,  1'b1);
    @(negedge clk);
    check("single_end_valid", rd_valid, 1'b0);
    check("single_idle_data", rd_data, 32'h0000_0001);

    // Backpressure: low word held for 10 cycles
    rd_ready = 1'b0;
    push_one(64'hABCD_0123_4567_89EF);
    wait_valid(5);
    for (int i = 0; i < 10; i++) begin
      check("bp_data", rd_data, 32'h4567_89EF);
      check("bp_last", rd_last, 1'b0);
      check("bp_valid", rd_valid, 1'b1);
      @(negedge clk);
    end
    rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_drained", rd_valid, 1'b0);

    // Burst with overflow
    rd_ready = 1'b0;
    for (int i = 1; i <= 20; i++) push_one(64'(i));
    check("burst_count",    count,    5'd16);
    check("burst_full",     full,     1'b1);
    check("burst_overflow", overflow, 1'b1);
    check("burst_drop_cnt", drop_cnt, 16'd3);
    check("burst_head",     rd_data,  32'd1);
    rd_ready = 1'b1;
    lo = '0;
    for (int i = 0; i < 60; i++) begin
      if (rd_valid && rd_ready) begin
        if (!rd_last) lo = rd_data;
        else got.push_back({rd_data, lo});
      end
      @(negedge clk);
    end
    check("burst_n_results", got.size(), 17);
    for (int i = 0; i < got.size(); i++) check("burst_order", got[i], 64'(i + 1));
    check("burst_ovf_sticky", overflow, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_overflow", overflow, 1'b0);
    check("clear_drop_cnt", drop_cnt, 16'd0);

    // Back-to-back: 4 results, 8 continuous words
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one({32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)});
    @(negedge clk);
    rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("b2b_valid", rd_valid, 1'b1);
      check("b2b_last",  rd_last,  k[0]);
      check("b2b_data",  rd_data,  k[0] ? 32'hB000_0000 + 32'(k/2) : 32'hA000_0000 + 32'(k/2));
      @(negedge clk);
    end
    check("b2b_end", rd_valid, 1'b0);

    // Clear colliding with done
    rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_one(64'h55 + 64'(i));
    @(negedge clk);
    check("coll_pre_count", count, 5'd5);
    check("coll_pre_valid", rd_valid, 1'b1);
    clear = 1'b1; done = 1'b1; timedata = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    clear = 1'b0; done = 1'b0;
    check("coll_count",    count,    5'd0);
    check("coll_empty",    empty,    1'b1);
    check("coll_valid",    rd_valid, 1'b0);
    check("coll_overflow", overflow, 1'b0);
    check("coll_drop_cnt", drop_cnt, 16'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("coll_no_output", rd_valid, 1'b0);
    end

    // Asynchronous reset while presenting the high word
    rd_ready = 1'b0;
    push_one(64'h1111_2222_3333_4444);
    wait_valid(5);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check("ar_pre_last", rd_last, 1'b1);
    check("ar_pre_data", rd_data, 32'h1111_2222);
    #2 reset_n = 1'b0;
    #1;
    check("ar_rd_valid", rd_valid, 1'b0);
    check("ar_rd_data",  rd_data,  32'h0);
    check("ar_rd_last",  rd_last,  1'b0);
    check("ar_count",    count,    5'd0);
    check("ar_empty",    empty,    1'b1);
    check("ar_full",     full,     1'b0);
    check("ar_overflow", overflow, 1'b0);
    check("ar_drop_cnt", drop_cnt, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic with alternating consumer pressure
    for (int c = 0; c < 3000; c++) begin
      int rdy_pct;
      rdy_pct  = ((c / 400) % 2 == 0) ? 20 : 90;
      done     = ($urandom_range(0, 99) < 55);
      timedata = {$urandom, $urandom};
      rd_ready = ($urandom_range(0, 99) < rdy_pct);
      clear    = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    done = 1'b0; clear = 1'b0; rd_ready = 1'b1;
    repeat (50) @(negedge clk);
    check("final_drained", rd_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
